// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a START/BUSY/DONE handshake.
// Shifts and rotates advance one bit per cycle; MUL is LSB-first shift-add.
module alu_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OPW   = 4,
    parameter int unsigned CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [OPW-1:0]   ALU_OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             BUSY,
    output logic             DONE,
    output logic             ILLEGAL
);

    localparam int unsigned LOGW = $clog2(WIDTH);

    localparam logic [OPW-1:0] OP_FWD  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_OR   = OPW'(3);
    localparam logic [OPW-1:0] OP_JUMP = OPW'(4);
    localparam logic [OPW-1:0] OP_BEQ  = OPW'(5);
    localparam logic [OPW-1:0] OP_MOV  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(9);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(10);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(11);
    localparam logic [OPW-1:0] OP_ROR  = OPW'(12);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [OPW-1:0]   r_op;
    logic [OPW-1:0]   w_op_nxt;
    logic [WIDTH-1:0] r_d1;
    logic [WIDTH-1:0] w_d1_nxt;
    logic [WIDTH-1:0] r_d2;
    logic [WIDTH-1:0] w_d2_nxt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNTW-1:0]  r_cnt;
    logic [CNTW-1:0]  w_cnt_nxt;
    logic             r_noshift;
    logic             w_noshift_nxt;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] w_result_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_illegal;
    logic             w_illegal_nxt;

    logic [CNTW-1:0]  w_amt;
    logic [CNTW-1:0]  w_lat;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_mac;
    logic [WIDTH-1:0] w_diff;

    // Effective shift amount and iteration count, decoded from the live inputs at accept
    always_comb begin
        w_amt = '0;
        if (ALU_OP == OP_SLL || ALU_OP == OP_SRL || ALU_OP == OP_SRA) begin
            w_amt = (DATA2 >= WIDTH'(WIDTH)) ? CNTW'(WIDTH) : CNTW'(DATA2);
        end else if (ALU_OP == OP_ROR) begin
            w_amt = CNTW'(DATA2[LOGW-1:0]);
        end
        w_lat = CNTW'(1);
        if (ALU_OP == OP_MUL) begin
            w_lat = CNTW'(WIDTH);
        end else if (w_amt != '0) begin
            w_lat = w_amt;
        end
    end

    // One iteration of the shifter and the multiply accumulator
    always_comb begin
        w_diff = r_d1 - r_d2;
        w_mac  = r_acc + (r_d2[0] ? r_d1 : '0);
        w_step = r_d1;
        if (!r_noshift) begin
            case (r_op)
                OP_SLL:  w_step = {r_d1[WIDTH-2:0], 1'b0};
                OP_SRL:  w_step = {1'b0, r_d1[WIDTH-1:1]};
                OP_SRA:  w_step = {r_d1[WIDTH-1], r_d1[WIDTH-1:1]};
                OP_ROR:  w_step = {r_d1[0], r_d1[WIDTH-1:1]};
                default: w_step = r_d1;
            endcase
        end
    end

    // Next-state and output logic
    always_comb begin
        w_state_nxt   = r_state;
        w_op_nxt      = r_op;
        w_d1_nxt      = r_d1;
        w_d2_nxt      = r_d2;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_noshift_nxt = r_noshift;
        w_result_nxt  = r_result;
        w_zero_nxt    = r_zero;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_nxt   = ST_EXEC;
                    w_busy_nxt    = 1'b1;
                    w_op_nxt      = ALU_OP;
                    w_d1_nxt      = DATA1;
                    w_d2_nxt      = DATA2;
                    w_acc_nxt     = '0;
                    w_cnt_nxt     = w_lat;
                    w_noshift_nxt = (w_amt == '0);
                end
            end
            ST_EXEC: begin
                w_cnt_nxt = r_cnt - CNTW'(1);
                if (r_op == OP_MUL) begin
                    w_acc_nxt = w_mac;
                    w_d1_nxt  = {r_d1[WIDTH-2:0], 1'b0};
                    w_d2_nxt  = {1'b0, r_d2[WIDTH-1:1]};
                end else begin
                    w_d1_nxt = w_step;
                end
                if (r_cnt == CNTW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_zero_nxt  = 1'b0;
                    case (r_op)
                        OP_FWD, OP_MOV: w_result_nxt = r_d1;
                        OP_ADD:         w_result_nxt = r_d1 + r_d2;
                        OP_AND:         w_result_nxt = r_d1 & r_d2;
                        OP_OR:          w_result_nxt = r_d1 | r_d2;
                        OP_JUMP:        w_zero_nxt   = 1'b1;
                        OP_BEQ: begin
                            w_result_nxt = w_diff;
                            w_zero_nxt   = (w_diff == '0);
                        end
                        OP_SUB:         w_result_nxt = w_diff;
                        OP_MUL:         w_result_nxt = w_mac;
                        OP_SLL, OP_SRL, OP_SRA, OP_ROR: w_result_nxt = w_step;
                        default: begin
                            w_result_nxt  = '0;
                            w_illegal_nxt = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state   <= ST_IDLE;
            r_op      <= '0;
            r_d1      <= '0;
            r_d2      <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_noshift <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op      <= w_op_nxt;
            r_d1      <= w_d1_nxt;
            r_d2      <= w_d2_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_noshift <= w_noshift_nxt;
            r_result  <= w_result_nxt;
            r_zero    <= w_zero_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    assign RESULT  = r_result;
    assign ZERO    = r_zero;
    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ILLEGAL = r_illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): per-cycle behavioural model plus directed vectors.
module tb_alu_seq;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [3:0] ALU_OP;
    logic [7:0] DATA1;
    logic [7:0] DATA2;
    logic [7:0] RESULT;
    logic       ZERO;
    logic       BUSY;
    logic       DONE;
    logic       ILLEGAL;

    int n_checks = 0;
    int n_pass   = 0;
    int g_k      = 0;
    bit chk_en   = 0;

    // Model state
    int         m_rem    = 0;
    logic       m_busy   = 0;
    logic       m_done   = 0;
    logic       m_ill    = 0;
    logic [7:0] m_result = 0;
    logic       m_zero   = 0;
    logic [7:0] p_result;
    logic       p_zero;
    logic       p_ill;

    alu_seq #(.WIDTH(8), .OPW(4)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .ALU_OP  (ALU_OP),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .RESULT  (RESULT),
        .ZERO    (ZERO),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ILLEGAL (ILLEGAL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Expected outcome of one operation, straight from the opcode table
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] prev, output logic [7:0] r, output logic z,
                                  output logic il, output int n);
        logic [15:0] wide;
        int amt;
        r = 8'h00; z = 1'b0; il = 1'b0; n = 1;
        amt = (b >= 8'd8) ? 8 : int'(b);
        case (op)
            4'h0, 4'h6: r = a;
            4'h1: r = a + b;
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: begin r = prev; z = 1'b1; end
            4'h5: begin r = a - b; z = (r == 8'h00); end
            4'h7: r = a - b;
            4'h8: begin wide = 16'(a) * 16'(b); r = wide[7:0]; n = 8; end
            4'h9: begin wide = {8'h00, a} << amt; r = wide[7:0]; n = (amt == 0) ? 1 : amt; end
            4'hA: begin r = a >> amt; n = (amt == 0) ? 1 : amt; end
            4'hB: begin r = 8'($signed(a) >>> amt); n = (amt == 0) ? 1 : amt; end
            4'hC: begin
                amt = int'(b) % 8;
                wide = {a, a} >> amt;
                r = wide[7:0];
                n = (amt == 0) ? 1 : amt;
            end
            default: il = 1'b1;
        endcase
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_rem = 0; m_busy = 0; m_done = 0; m_ill = 0; m_result = 0; m_zero = 0;
        end else begin
            m_done = 0;
            m_ill  = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_result = p_result;
                    m_zero   = p_zero;
                    m_ill    = p_ill;
                    m_done   = 1;
                    m_busy   = 0;
                end
            end else if (START) begin
                model(ALU_OP, DATA1, DATA2, m_result, p_result, p_zero, p_ill, m_rem);
                m_busy = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge CLK) begin
        if (RESET && chk_en) begin
            chk("cyc_busy", 32'(BUSY), 32'(m_busy));
            chk("cyc_done", 32'(DONE), 32'(m_done));
            chk("cyc_illegal", 32'(ILLEGAL), 32'(m_ill));
            chk("cyc_result", 32'(RESULT), 32'(m_result));
            chk("cyc_zero", 32'(ZERO), 32'(m_zero));
        end
    end

    task automatic tick();
        @(negedge CLK);
        g_k++;
    endtask

    // Present an op; returns at the negedge just after the accept edge
    task automatic issue(input logic [3:0] op, input logic [7:0] d1, input logic [7:0] d2);
        @(negedge CLK);
        START = 1'b1; ALU_OP = op; DATA1 = d1; DATA2 = d2;
        @(negedge CLK);
        g_k = 0;
        START = 1'b0; ALU_OP = op ^ 4'h5; DATA1 = ~d1; DATA2 = 8'($urandom);
    endtask

    task automatic wait_done(input logic [7:0] er, input logic ez, input logic ei,
                             input int en, input string nm);
        bit seen;
        seen = 0;
        while (!seen && g_k < 40) begin
            tick();
            if (DONE) seen = 1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, "_latency"}, 32'(g_k), 32'(en));
            chk({nm, "_result"}, 32'(RESULT), 32'(er));
            chk({nm, "_zero"}, 32'(ZERO), 32'(ez));
            chk({nm, "_illegal"}, 32'(ILLEGAL), 32'(ei));
        end
    endtask

    task automatic run(input logic [3:0] op, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [7:0] er, input logic ez, input logic ei, input int en,
                       input string nm);
        issue(op, d1, d2);
        wait_done(er, ez, ei, en, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; START = 1'b0; ALU_OP = 4'h0; DATA1 = 8'h00; DATA2 = 8'h00;
        repeat (2) @(negedge CLK);
        chk("rst_result", 32'(RESULT), 32'h0);
        chk("rst_zero", 32'(ZERO), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_illegal", 32'(ILLEGAL), 32'h0);
        #3 RESET = 1'b1;
        chk_en = 1;

        run(4'h1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1, "add");
        run(4'h8, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 8, "mul_13x11");
        run(4'h8, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 8, "mul_ffxff");
        run(4'h5, 8'h25, 8'h25, 8'h00, 1'b1, 1'b0, 1, "beq_eq");
        run(4'h5, 8'h25, 8'h26, 8'hFF, 1'b0, 1'b0, 1, "beq_ne");
        run(4'h4, 8'h12, 8'h34, 8'hFF, 1'b1, 1'b0, 1, "jump");
        run(4'hB, 8'h90, 8'd3, 8'hF2, 1'b0, 1'b0, 3, "sra_3");
        run(4'hB, 8'h90, 8'd200, 8'hFF, 1'b0, 1'b0, 8, "sra_200");
        run(4'h9, 8'h01, 8'd0, 8'h01, 1'b0, 1'b0, 1, "sll_0");
        run(4'hC, 8'h81, 8'd9, 8'hC0, 1'b0, 1'b0, 1, "ror_9");
        run(4'hC, 8'h81, 8'd3, 8'h30, 1'b0, 1'b0, 3, "ror_3");
        run(4'hA, 8'h80, 8'd7, 8'h01, 1'b0, 1'b0, 7, "srl_7");
        run(4'h9, 8'h03, 8'd8, 8'h00, 1'b0, 1'b0, 8, "sll_8");
        run(4'h7, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1, "sub");
        run(4'h2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1, "and");
        run(4'h3, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1, "or");
        run(4'h0, 8'hA5, 8'h5A, 8'hA5, 1'b0, 1'b0, 1, "fwd");
        run(4'h6, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b0, 1, "mov");

        // START pulsed mid-MUL is ignored
        issue(4'h8, 8'd3, 8'd5);
        tick(); tick();
        START = 1'b1; ALU_OP = 4'h1; DATA1 = 8'h01; DATA2 = 8'h01;
        tick();
        START = 1'b0;
        wait_done(8'h0F, 1'b0, 1'b0, 8, "mul_ignore_start");

        // START held in the DONE cycle is taken on the very next edge
        issue(4'h8, 8'd13, 8'd11);
        wait_done(8'h8F, 1'b0, 1'b0, 8, "b2b_mul");
        START = 1'b1; ALU_OP = 4'h1; DATA1 = 8'h12; DATA2 = 8'h34;
        @(negedge CLK);
        g_k = 0;
        START = 1'b0;
        chk("b2b_busy", 32'(BUSY), 32'h1);
        wait_done(8'h46, 1'b0, 1'b0, 1, "b2b_add");

        // Asynchronous reset in the 4th cycle of a MUL
        issue(4'h8, 8'd13, 8'd11);
        tick(); tick(); tick();
        #2 RESET = 1'b0;
        #1;
        chk("mid_rst_result", 32'(RESULT), 32'h0);
        chk("mid_rst_zero", 32'(ZERO), 32'h0);
        chk("mid_rst_busy", 32'(BUSY), 32'h0);
        chk("mid_rst_done", 32'(DONE), 32'h0);
        chk("mid_rst_illegal", 32'(ILLEGAL), 32'h0);
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_no_done", 32'(DONE), 32'h0);
        end

        run(4'h1, 8'h05, 8'h06, 8'h0B, 1'b0, 1'b0, 1, "add_after_rst");
        run(4'hE, 8'h55, 8'hAA, 8'h00, 1'b0, 1'b1, 1, "illegal_e");
        run(4'hD, 8'h11, 8'h22, 8'h00, 1'b0, 1'b1, 1, "illegal_d");

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
